// File: rtl/mc_trace_pkg.sv
// Shared definitions for the multicycle-core trace monitor: trace entry layout and a saturating increment.
// The entry grows by the register-write fields when MC_TRACE_REGWRITE_EN is defined.
package mc_trace_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_META_W = 1 + RF_ADDR_W;
    localparam int SAT_W     = 64;

    // Layout, MSB first: {pc, instr[, rf_we, rf_waddr, rf_wdata]}
    function automatic int entry_width(input int xlen);
`ifdef MC_TRACE_REGWRITE_EN
        return 3 * xlen + RF_META_W;
`else
        return 2 * xlen;
`endif
    endfunction

    function automatic int instr_lsb(input int xlen);
`ifdef MC_TRACE_REGWRITE_EN
        return xlen + RF_META_W;
`else
        return 0;
`endif
    endfunction

    function automatic int pc_lsb(input int xlen);
        return instr_lsb(xlen) + xlen;
    endfunction

    // Callers zero-extend their counter and pass its all-ones value as max_v.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max_v);
        return (v == max_v) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/mc_trace_fifo.sv
// Circular trace buffer with registered pop data, occupancy level and sticky overflow.
// WRAP=1 overwrites the oldest entry when full; WRAP=0 drops the incoming entry.
module mc_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 64,
    parameter bit WRAP  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             rd_valid_q, rd_valid_d;
    logic [W-1:0]     rd_data_q, rd_data_d;
    logic             is_full, is_empty, do_pop, do_write;

    assign is_empty = (level_q == '0);
    assign is_full  = (level_q == LVL_W'(DEPTH));
    assign do_pop   = pop & ~is_empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        do_write   = 1'b0;

        if (do_pop) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        end

        if (push) begin
            if (!is_full || do_pop) begin
                // A same-cycle pop frees the slot, so a full buffer still takes the entry cleanly.
                do_write = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else if (WRAP) begin
                do_write   = 1'b1;
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                overflow_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (do_write && !do_pop && !is_full) begin
            level_d = level_q + LVL_W'(1);
        end else if (do_pop && !do_write) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = is_empty;
    assign full     = is_full;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/mc_trace_monitor.sv
// Execution monitor for the multicycle RISC-V core: cycle/instret counters, retire trace, halt and timeout flags.
// Define MC_TRACE_REGWRITE_EN to log register writes in the trace and shadow register WATCH_REG.
module mc_trace_monitor
    import mc_trace_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 16,
    parameter int CNT_W       = 32,
    parameter int MAX_CYCLES  = 100,
    parameter int HALT_REPEAT = 2,
    parameter int WRAP        = 1
`ifdef MC_TRACE_REGWRITE_EN
    ,
    parameter int WATCH_REG   = 2
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         retire,
    input  logic [XLEN-1:0]              pc,
    input  logic [XLEN-1:0]              instr,
`ifdef MC_TRACE_REGWRITE_EN
    input  logic                         rf_we,
    input  logic [RF_ADDR_W-1:0]         rf_waddr,
    input  logic [XLEN-1:0]              rf_wdata,
    output logic [XLEN-1:0]              watch_val,
`endif
    input  logic                         rd_en,
    output logic [entry_width(XLEN)-1:0] rd_data,
    output logic                         rd_valid,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         overflow,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [CNT_W-1:0]             instret_count,
    output logic                         halted,
    output logic                         timeout
);

    localparam int              EW       = entry_width(XLEN);
    localparam int              RPT_W    = $clog2(HALT_REPEAT + 1);
    localparam logic [SAT_W-1:0] CNT_ONES = SAT_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [RPT_W-1:0] repeat_q, repeat_d;
    logic [XLEN-1:0]  last_pc_q, last_pc_d;
    logic             halted_q, halted_d;
    logic             timeout_q, timeout_d;
    logic             stop, accept;
    logic [EW-1:0]    entry;

    assign stop   = halted_q | timeout_q;
    assign accept = retire & ~stop;

`ifdef MC_TRACE_REGWRITE_EN
    assign entry = {pc, instr, rf_we, rf_waddr, rf_wdata};
`else
    assign entry = {pc, instr};
`endif

    always_comb begin
        cycle_count_d = cycle_count_q;
        instret_d     = instret_q;
        repeat_d      = repeat_q;
        last_pc_d     = last_pc_q;
        halted_d      = halted_q;
        timeout_d     = timeout_q;

        if (!stop) begin
            cycle_count_d = CNT_W'(sat_inc(SAT_W'(cycle_count_q), CNT_ONES));
            if (MAX_CYCLES != 0 && cycle_count_d == CNT_W'(MAX_CYCLES)) begin
                timeout_d = 1'b1;
            end
        end

        if (accept) begin
            instret_d = CNT_W'(sat_inc(SAT_W'(instret_q), CNT_ONES));
            // A zero repeat count means no retire has been seen since reset, so nothing to match.
            repeat_d  = (repeat_q != '0 && pc == last_pc_q) ? repeat_q + RPT_W'(1) : RPT_W'(1);
            last_pc_d = pc;
            if (repeat_d == RPT_W'(HALT_REPEAT)) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_q <= '0;
            instret_q     <= '0;
            repeat_q      <= '0;
            last_pc_q     <= '0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            cycle_count_q <= cycle_count_d;
            instret_q     <= instret_d;
            repeat_q      <= repeat_d;
            last_pc_q     <= last_pc_d;
            halted_q      <= halted_d;
            timeout_q     <= timeout_d;
        end
    end

`ifdef MC_TRACE_REGWRITE_EN
    logic [XLEN-1:0] watch_q, watch_d;

    // x0 is hardwired to zero, so a WATCH_REG of 0 never captures anything.
    always_comb begin
        watch_d = watch_q;
        if (accept && rf_we && WATCH_REG != 0 && rf_waddr == RF_ADDR_W'(WATCH_REG)) begin
            watch_d = rf_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            watch_q <= '0;
        end else begin
            watch_q <= watch_d;
        end
    end

    assign watch_val = watch_q;
`endif

    mc_trace_fifo #(
        .DEPTH (DEPTH),
        .W     (EW),
        .WRAP  (WRAP != 0)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (entry),
        .pop       (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .overflow  (overflow)
    );

    assign cycle_count   = cycle_count_q;
    assign instret_count = instret_q;
    assign halted        = halted_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_mc_trace_monitor.sv
// Bench for mc_trace_monitor: a WRAP=1 and a WRAP=0 instance share stimulus and are checked against a queue model.
module tb_mc_trace_monitor;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;
    localparam int MAXC  = 100;
    localparam int HREP  = 2;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef MC_TRACE_REGWRITE_EN
    localparam int EW    = 3 * XLEN + 6;
`else
    localparam int EW    = 2 * XLEN;
`endif
    localparam longint CMAX = (64'd1 << CNT_W) - 1;

    logic            clk = 1'b0;
    logic            rst, retire, rd_en;
    logic [XLEN-1:0] pc, instr;
`ifdef MC_TRACE_REGWRITE_EN
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [XLEN-1:0] watch_o [2];
`endif

    logic [EW-1:0]    rd_o    [2];
    logic             rv_o    [2];
    logic             empty_o [2];
    logic             full_o  [2];
    logic             ovf_o   [2];
    logic             halt_o  [2];
    logic             to_o    [2];
    logic [LW-1:0]    lvl_o   [2];
    logic [CNT_W-1:0] cyc_o   [2];
    logic [CNT_W-1:0] ins_o   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Instance 0 overwrites when full, instance 1 drops.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            mc_trace_monitor #(
                .XLEN        (XLEN),
                .DEPTH       (DEPTH),
                .CNT_W       (CNT_W),
                .MAX_CYCLES  (MAXC),
                .HALT_REPEAT (HREP),
                .WRAP        ((gi == 0) ? 1 : 0)
            ) u_dut (
                .clk           (clk),
                .rst           (rst),
                .retire        (retire),
                .pc            (pc),
                .instr         (instr),
`ifdef MC_TRACE_REGWRITE_EN
                .rf_we         (rf_we),
                .rf_waddr      (rf_waddr),
                .rf_wdata      (rf_wdata),
                .watch_val     (watch_o[gi]),
`endif
                .rd_en         (rd_en),
                .rd_data       (rd_o[gi]),
                .rd_valid      (rv_o[gi]),
                .empty         (empty_o[gi]),
                .full          (full_o[gi]),
                .level         (lvl_o[gi]),
                .overflow      (ovf_o[gi]),
                .cycle_count   (cyc_o[gi]),
                .instret_count (ins_o[gi]),
                .halted        (halt_o[gi]),
                .timeout       (to_o[gi])
            );
        end
    endgenerate

    // ---------------- behavioural model ----------------
    logic [EW-1:0]   mq [2][$];
    logic [EW-1:0]   m_rd  [2];
    bit              m_rv  [2];
    bit              m_ovf [2];
    longint          m_cyc, m_ins;
    int              m_rep;
    logic [XLEN-1:0] m_last;
    bit              m_halt, m_to;
    logic [XLEN-1:0] m_watch;

    function automatic logic [EW-1:0] cur_entry();
`ifdef MC_TRACE_REGWRITE_EN
        return {pc, instr, rf_we, rf_waddr, rf_wdata};
`else
        return {pc, instr};
`endif
    endfunction

    always @(posedge clk) begin
        bit stop, acc;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mq[i].delete();
                m_rd[i]  = '0;
                m_rv[i]  = 1'b0;
                m_ovf[i] = 1'b0;
            end
            m_cyc = 0; m_ins = 0; m_rep = 0; m_last = '0;
            m_halt = 1'b0; m_to = 1'b0; m_watch = '0;
        end else begin
            stop = m_halt || m_to;
            acc  = retire && !stop;
            if (!stop) begin
                if (m_cyc < CMAX) m_cyc++;
                if (m_cyc == MAXC) m_to = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                m_rv[i] = 1'b0;
                if (rd_en && mq[i].size() > 0) begin
                    m_rd[i] = mq[i].pop_front();
                    m_rv[i] = 1'b1;
                end
                if (acc) begin
                    if (mq[i].size() < DEPTH) begin
                        mq[i].push_back(cur_entry());
                    end else begin
                        m_ovf[i] = 1'b1;
                        if (i == 0) begin
                            void'(mq[i].pop_front());
                            mq[i].push_back(cur_entry());
                        end
                    end
                end
            end
            if (acc) begin
                if (m_ins < CMAX) m_ins++;
                m_rep  = (m_rep > 0 && pc == m_last) ? m_rep + 1 : 1;
                m_last = pc;
                if (m_rep >= HREP) m_halt = 1'b1;
`ifdef MC_TRACE_REGWRITE_EN
                if (rf_we && rf_waddr == 5'd2) m_watch = rf_wdata;
`endif
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d.rd_valid", i), 128'(rv_o[i]), 128'(m_rv[i]));
            chk($sformatf("dut%0d.rd_data", i), 128'(rd_o[i]), 128'(m_rd[i]));
            chk($sformatf("dut%0d.level", i), 128'(lvl_o[i]), 128'(mq[i].size()));
            chk($sformatf("dut%0d.empty", i), 128'(empty_o[i]), 128'(mq[i].size() == 0));
            chk($sformatf("dut%0d.full", i), 128'(full_o[i]), 128'(mq[i].size() == DEPTH));
            chk($sformatf("dut%0d.overflow", i), 128'(ovf_o[i]), 128'(m_ovf[i]));
            chk($sformatf("dut%0d.cycle_count", i), 128'(cyc_o[i]), 128'(m_cyc));
            chk($sformatf("dut%0d.instret", i), 128'(ins_o[i]), 128'(m_ins));
            chk($sformatf("dut%0d.halted", i), 128'(halt_o[i]), 128'(m_halt));
            chk($sformatf("dut%0d.timeout", i), 128'(to_o[i]), 128'(m_to));
`ifdef MC_TRACE_REGWRITE_EN
            chk($sformatf("dut%0d.watch_val", i), 128'(watch_o[i]), 128'(m_watch));
`endif
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [XLEN-1:0] pc_of(input int i);
        return rd_o[i][EW-1 -: XLEN];
    endfunction

    task automatic cyc(input logic r, input logic [XLEN-1:0] p, input logic pop);
        retire = r;
        pc     = p;
        instr  = 32'h0000_0013 | (p << 8);
        rd_en  = pop;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; retire = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; retire = 1'b0; rd_en = 1'b0; pc = '0; instr = '0;
`ifdef MC_TRACE_REGWRITE_EN
        rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
`endif
        do_reset();
        chk("reset.empty", 128'(empty_o[0]), 128'(1));
        chk("reset.level", 128'(lvl_o[0]), 128'(0));
        chk("reset.cycle_count", 128'(cyc_o[0]), 128'(0));
        $display("[TB] reset done");

        // Five retires then five pops in FIFO order.
        for (int k = 0; k < 5; k++) cyc(1'b1, XLEN'(4 * k), 1'b0);
        chk("basic.instret", 128'(ins_o[0]), 128'(5));
        chk("basic.level", 128'(lvl_o[1]), 128'(5));
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, '0, 1'b1);
            chk($sformatf("basic.pop%0d.pc", k), 128'(pc_of(0)), 128'(4 * k));
            chk($sformatf("basic.pop%0d.valid", k), 128'(rv_o[0]), 128'(1));
            $display("[TB] pop %0d pc=%0h", k, pc_of(0));
        end
        cyc(1'b0, '0, 1'b1);
        chk("basic.empty_pop.valid", 128'(rv_o[0]), 128'(0));
        chk("basic.empty_pop.hold", 128'(pc_of(0)), 128'(32'h10));
        chk("basic.empty", 128'(empty_o[0]), 128'(1));

        // Twenty retires, no pops: overwrite versus drop.
        do_reset();
        for (int k = 0; k < 20; k++) cyc(1'b1, XLEN'(4 * k), 1'b0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("fill.dut%0d.full", i), 128'(full_o[i]), 128'(1));
            chk($sformatf("fill.dut%0d.overflow", i), 128'(ovf_o[i]), 128'(1));
            chk($sformatf("fill.dut%0d.level", i), 128'(lvl_o[i]), 128'(16));
            chk($sformatf("fill.dut%0d.instret", i), 128'(ins_o[i]), 128'(20));
        end
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, '0, 1'b1);
            if (k == 0) begin
                chk("wrap.first_pc", 128'(pc_of(0)), 128'(32'h10));
                chk("drop.first_pc", 128'(pc_of(1)), 128'(32'h0));
            end
            if (k == 15) begin
                chk("wrap.last_pc", 128'(pc_of(0)), 128'(32'h4C));
                chk("drop.last_pc", 128'(pc_of(1)), 128'(32'h3C));
            end
            $display("[TB] drain %0d wrap_pc=%0h drop_pc=%0h", k, pc_of(0), pc_of(1));
        end

        // Simultaneous push and pop on a full buffer: no overflow in either mode.
        do_reset();
        for (int k = 0; k < 16; k++) cyc(1'b1, XLEN'(32'h40 + 4 * k), 1'b0);
        cyc(1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("pushpop.dut%0d.pc", i), 128'(pc_of(i)), 128'(32'h40));
            chk($sformatf("pushpop.dut%0d.overflow", i), 128'(ovf_o[i]), 128'(0));
            chk($sformatf("pushpop.dut%0d.level", i), 128'(lvl_o[i]), 128'(16));
        end
        for (int k = 0; k < 16; k++) cyc(1'b0, '0, 1'b1);
        chk("pushpop.last_pc", 128'(pc_of(1)), 128'(32'h200));
        chk("pushpop.empty", 128'(empty_o[0]), 128'(1));

        // Halt on a self-loop; later retires ignored, pops still drain.
        do_reset();
        cyc(1'b1, 32'h8, 1'b0);
        chk("halt.not_yet", 128'(halt_o[0]), 128'(0));
        cyc(1'b1, 32'h8, 1'b0);
        chk("halt.set", 128'(halt_o[0]), 128'(1));
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'hC, 1'b0);
        chk("halt.cycles_frozen", 128'(cyc_o[0]), 128'(2));
        chk("halt.instret", 128'(ins_o[0]), 128'(2));
        chk("halt.level", 128'(lvl_o[0]), 128'(2));
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, '0, 1'b1);
            chk($sformatf("halt.pop%0d.pc", k), 128'(pc_of(0)), 128'(32'h8));
        end
        chk("halt.drained", 128'(empty_o[1]), 128'(1));
        $display("[TB] halt scenario done, cycle_count=%0d", cyc_o[0]);

        // Timeout at cycle 100, then reset mid-run.
        do_reset();
        for (int k = 0; k < 3; k++) cyc(1'b1, XLEN'(32'h100 + 4 * k), 1'b0);
        for (int k = 0; k < 96; k++) cyc(1'b0, '0, 1'b0);
        chk("timeout.at99.count", 128'(cyc_o[0]), 128'(99));
        chk("timeout.at99.flag", 128'(to_o[0]), 128'(0));
        cyc(1'b0, '0, 1'b0);
        chk("timeout.at100.count", 128'(cyc_o[0]), 128'(100));
        chk("timeout.at100.flag", 128'(to_o[0]), 128'(1));
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h300, 1'b0);
        chk("timeout.frozen", 128'(cyc_o[1]), 128'(100));
        chk("timeout.instret", 128'(ins_o[1]), 128'(3));
        rst = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        chk("midreset.cycle_count", 128'(cyc_o[0]), 128'(0));
        chk("midreset.timeout", 128'(to_o[0]), 128'(0));
        chk("midreset.level", 128'(lvl_o[0]), 128'(0));
        chk("midreset.empty", 128'(empty_o[0]), 128'(1));
        chk("midreset.rd_valid", 128'(rv_o[0]), 128'(0));
        chk("midreset.rd_data", 128'(rd_o[0]), 128'(0));
        rst = 1'b0; rd_en = 1'b0;
        cyc(1'b0, '0, 1'b1);
        chk("midreset.pop_ignored", 128'(rv_o[0]), 128'(0));

`ifdef MC_TRACE_REGWRITE_EN
        // Register-write shadow and widened trace entry.
        do_reset();
        rf_we = 1'b1; rf_waddr = 5'd2; rf_wdata = 32'hDEADBEEF;
        cyc(1'b1, 32'h400, 1'b0);
        chk("watch.write_x2", 128'(watch_o[0]), 128'(32'hDEADBEEF));
        rf_waddr = 5'd0; rf_wdata = 32'h1;
        cyc(1'b1, 32'h404, 1'b0);
        chk("watch.write_x0", 128'(watch_o[0]), 128'(32'hDEADBEEF));
        rf_we = 1'b0; rf_waddr = 5'd2; rf_wdata = 32'h5;
        cyc(1'b1, 32'h408, 1'b0);
        chk("watch.no_we", 128'(watch_o[1]), 128'(32'hDEADBEEF));
        cyc(1'b0, '0, 1'b1);
        chk("entry.wdata", 128'(rd_o[0][XLEN-1:0]), 128'(32'hDEADBEEF));
        chk("entry.waddr", 128'(rd_o[0][XLEN+4:XLEN]), 128'(2));
        chk("entry.we", 128'(rd_o[0][XLEN+5]), 128'(1));
        chk("entry.instr", 128'(rd_o[0][XLEN+6 +: XLEN]), 128'(32'h0004_0013));
        chk("entry.pc", 128'(pc_of(0)), 128'(32'h400));
        rf_we = 1'b0;
`endif

        cyc(1'b0, '0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_trace_monitor.md
Name: mc_trace_monitor

Overview:
- Synthesizable execution monitor for the multicycle RISC-V core. Hardware successor to bench-side cycle printing.
- Counts cycles and retired instructions.
- Captures a {PC, IR} trace of retired instructions into a parametrised circular buffer.
- Flags halt (self-loop) and cycle-limit timeout, so benches and on-chip debug can stop on an event rather than a fixed delay.

Parameters:
- XLEN, 32, PC/instruction width
- DEPTH, 16, trace entries; power of two, >=2
- CNT_W, 32, cycle/instret counter width
- MAX_CYCLES, 100, timeout threshold in cycles; 0 disables timeout
- HALT_REPEAT, 2, consecutive retires at the same PC that declare halt; >=2
- WRAP, 1, 1 = overwrite oldest entry when full; 0 = drop new entries and flag overflow

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- retire  in  1  one-cycle strobe; the instruction in pc/instr completes this cycle
- pc  in  XLEN  PC of the retiring instruction
- instr  in  XLEN  IR of the retiring instruction
- rd_en  in  1  pop oldest trace entry
- rd_data  out  2*XLEN  {pc, instr}; registered
- rd_valid  out  1  rd_data valid, one cycle after an accepted pop
- empty  out  1  no entries
- full  out  1  DEPTH entries
- level  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky; an entry was lost (dropped or overwritten)
- cycle_count  out  CNT_W  cycles since reset, saturating
- instret_count  out  CNT_W  accepted retires, saturating
- halted  out  1  sticky halt detected
- timeout  out  1  sticky cycle limit reached

Behaviour:
- Reset (rst sampled high at posedge): all outputs 0; empty=1; pointers, counters and repeat counter cleared. Reset mid-operation discards buffer contents.
- Stop condition: stop = halted | timeout.
- cycle_count increments every cycle while !stop. It saturates at all-ones.
- retire is accepted when retire=1 and !stop. On acceptance:
  - instret_count increments (saturating).
  - The entry is written at the write pointer. It is visible to a pop from the next cycle.
- Repeat counter:
  - Cleared on reset.
  - On an accepted retire: if pc equals the last accepted PC, increment; else set to 1.
  - Reaching HALT_REPEAT sets halted in the same edge. That retire is still logged.
- timeout is set on the edge where cycle_count becomes MAX_CYCLES (when MAX_CYCLES!=0).
- Pops continue after stop, so the trace can be drained.
- Pop accepted when rd_en & !empty:
  - rd_data is loaded with the oldest entry.
  - rd_valid=1 the next cycle, else 0.
  - rd_en while empty is ignored: rd_valid=0, rd_data holds.
- Full, no pop:
  - WRAP=1: overwrite oldest, advance read pointer, overflow=1, level stays DEPTH.
  - WRAP=0: entry dropped, overflow=1, pointers unchanged. instret_count still increments.
- Simultaneous push and pop:
  - Both are accepted and level is unchanged; pop returns the pre-push oldest entry.
  - Applies when full as well, for both WRAP modes: no overflow.
- Pointers: log2(DEPTH) bits, natural wrap-around. full/empty are derived from level.

Optional Feature:
- Macro: MC_TRACE_REGWRITE_EN.
- Defined:
  - Adds inputs rf_we (1), rf_waddr (5), rf_wdata (XLEN), all valid with retire.
  - Entry widens to {pc, instr, rf_we, rf_waddr, rf_wdata}; rd_data width becomes 2*XLEN+6+XLEN.
  - Adds parameter WATCH_REG (default 2) and output watch_val (XLEN, reset 0). watch_val updates on an accepted retire with rf_we=1, rf_waddr==WATCH_REG!=0. Writes to x0 are never shadowed.
- Undefined: ports, parameter and fields are absent; behaviour is as above.

Decomposition:
- Package mc_trace_pkg: entry field offsets/widths, and a saturating-increment function.
- One natural sub-module, mc_trace_fifo: parametrised DEPTH/width circular buffer with WRAP mode, level, full/empty and overflow.
- The top holds counters, halt/timeout logic and the watch shadow.

Test Plan:
- Reset then 5 retires at PCs 0x0, 0x4, 0x8, 0xC, 0x10 and 5 pops -> instret_count=5, FIFO-order rd_data, rd_valid one cycle after each rd_en, then empty=1.
- DEPTH=16, WRAP=1, 20 retires (PC=4*i), no pops -> full=1, overflow=1, level=16, first pop returns PC 0x10.
- WRAP=0, same stimulus -> overflow=1, first pop returns PC 0x0, last returns 0x3C, instret_count=20.
- Retires at 0x8, 0x8 with HALT_REPEAT=2 -> halted=1 after the second; cycle_count freezes; further retires are ignored; pops still drain.
- MAX_CYCLES=100, no retires -> timeout=1 exactly when cycle_count=100; assert rst mid-run -> all outputs cleared next edge.
- MC_TRACE_REGWRITE_EN: retire with rf_we=1, waddr=2, wdata=0xDEADBEEF -> watch_val=0xDEADBEEF; then waddr=0, wdata=0x1 -> watch_val unchanged; trace entry fields match.
